// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains async-FIFO entries and packs PACK_FACTOR of them per valid/ready output word.
// Optional out_parity port enabled by defining FIFO_RD_PACKER_PARITY_EN.
module fifo_rd_packer #(
  parameter int DATA_WIDTH  = 4,
  parameter int PACK_FACTOR = 4,
  parameter int OUT_WIDTH   = DATA_WIDTH * PACK_FACTOR,
  parameter int LANE_W      = $clog2(PACK_FACTOR) + 1
) (
  input  logic                  r_clk,
  input  logic                  rrst,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  r_en,
  input  logic                  flush,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [LANE_W-1:0]     out_lanes,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FIFO_RD_PACKER_PARITY_EN
  ,
  output logic                  out_parity
`endif
);
  localparam int CW = $clog2(PACK_FACTOR);
  localparam logic [CW-1:0] LAST = CW'(PACK_FACTOR - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic inflight_q;
  logic [PACK_FACTOR-1:0][DATA_WIDTH-1:0] asm_q, asm_d, asm_w;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [LANE_W-1:0] out_lanes_q, out_lanes_d;
  logic out_valid_q, out_valid_d;
  logic [CW:0] landing;
  logic stall, complete, emit;
  // A read issued now lands one edge later; block it only if it would complete a word into a stuck output.
  assign landing  = {1'b0, cnt_q} + (CW+1)'(inflight_q);
  assign stall    = out_valid_q && !out_ready && landing == (CW+1)'(PACK_FACTOR - 1);
  assign r_en     = !rrst && !r_empty && !flush && !stall;
  assign complete = inflight_q && cnt_q == LAST;
  assign emit     = flush && !inflight_q && cnt_q != '0 && (!out_valid_q || out_ready);
  always_comb begin
    asm_w = asm_q;
    if (inflight_q) asm_w[cnt_q] = rdata;
    asm_d       = (complete || emit) ? '0 : asm_w;
    cnt_d       = (complete || emit) ? '0 : cnt_q + CW'(inflight_q);
    out_data_d  = complete ? asm_w : emit ? asm_q : out_data_q;
    out_lanes_d = complete ? LANE_W'(PACK_FACTOR) : emit ? LANE_W'(cnt_q) : out_lanes_q;
    out_valid_d = complete || emit || (out_valid_q && !out_ready);
  end
  always_ff @(posedge r_clk) begin
    if (rrst) begin
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_lanes_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      inflight_q  <= r_en;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_lanes_q <= out_lanes_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_lanes = out_lanes_q;
  assign out_valid = out_valid_q;
`ifdef FIFO_RD_PACKER_PARITY_EN
  logic out_parity_q;
  always_ff @(posedge r_clk) begin
    if (rrst) out_parity_q <= 1'b0;
    else out_parity_q <= ^out_data_d;
  end
  assign out_parity = out_parity_q;
`endif
endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: scoreboard bench for fifo_rd_packer with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_packer;
  localparam int DW = 4;
  localparam int PF = 4;
  localparam int OW = 16;
  localparam int LW = 3;
  logic r_clk = 0, rrst = 1, r_empty = 1, flush = 0, out_ready = 0;
  logic r_en, out_valid;
  logic [DW-1:0] rdata = '0;
  logic [OW-1:0] out_data;
  logic [LW-1:0] out_lanes;
`ifdef FIFO_RD_PACKER_PARITY_EN
  logic out_parity;
`endif
  int tests = 0, fails = 0, reads = 0, valid_cycles = 0;
  logic [DW-1:0] fifo[$];
  logic [OW+LW-1:0] exp_q[$];
  logic hold_pending = 0;
  logic [OW-1:0] hold_data = '0;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_FACTOR(PF)) dut (
    .r_clk(r_clk), .rrst(rrst), .r_empty(r_empty), .rdata(rdata), .r_en(r_en),
    .flush(flush), .out_data(out_data), .out_lanes(out_lanes), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FIFO_RD_PACKER_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 r_clk = ~r_clk;

  task automatic push(input logic [DW-1:0] v);
    fifo.push_back(v);
    r_empty = 0;
  endtask

  task automatic expect_word(input logic [OW-1:0] d, input logic [LW-1:0] l);
    exp_q.push_back({d, l});
  endtask

  // One clock: observe at negedge, then model the FIFO read data arriving just after the edge.
  task automatic tick();
    logic do_pop;
    logic [OW+LW-1:0] e;
    @(negedge r_clk);
    do_pop = r_en && fifo.size() > 0;
    if (out_valid) valid_cycles++;
    if (hold_pending) begin
      tests++;
      if (out_data !== hold_data) begin
        fails++;
        $display("FAIL hold_stable out_data=%h required %h", out_data, hold_data);
      end
    end
    hold_pending = !rrst && out_valid && !out_ready;
    hold_data = out_data;
    if (!rrst && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word out_data=%h out_lanes=%0d required none", out_data, out_lanes);
      end else begin
        e = exp_q.pop_front();
        if ({out_data, out_lanes} !== e) begin
          fails++;
          $display("FAIL scoreboard out_data=%h out_lanes=%0d required %h lanes %0d",
                   out_data, out_lanes, e[OW+LW-1:LW], e[LW-1:0]);
        end
      end
    end
    @(posedge r_clk);
    #1;
    if (do_pop) begin
      rdata = fifo.pop_front();
      reads++;
    end
    r_empty = (fifo.size() == 0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rrst = 1;
    push(4'h9);
    #1;
    tests++;
    if (r_en !== 1'b0) begin fails++; $display("FAIL reset_ren r_en=%b required 0", r_en); end
    run(2);
    fifo.delete();
    r_empty = 1;
    tests++;
    if ({out_valid, out_data, out_lanes} !== '0) begin
      fails++;
      $display("FAIL reset_outputs valid=%b data=%h lanes=%0d required all 0", out_valid, out_data, out_lanes);
    end
    rrst = 0;
    run(2);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle out_valid=%b required 0", out_valid); end
  endtask

  task automatic test_basic();
    int r0, v0;
    out_ready = 1;
    r0 = reads; v0 = valid_cycles;
    expect_word(16'h4321, 3'd4);
    for (int i = 1; i <= 4; i++) push(DW'(i));
    run(12);
    tests++;
    if (reads - r0 != 4) begin fails++; $display("FAIL basic_reads got %0d required 4", reads - r0); end
    tests++;
    if (valid_cycles - v0 != 1) begin fails++; $display("FAIL basic_valid_cycles got %0d required 1", valid_cycles - v0); end
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL basic_drain pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int r0;
    out_ready = 0;
    r0 = reads;
    expect_word(16'h4321, 3'd4);
    expect_word(16'h8765, 3'd4);
    for (int i = 1; i <= 8; i++) push(DW'(i));
    run(20);
    tests++;
    if (reads - r0 != 7) begin fails++; $display("FAIL bp_reads got %0d required 7", reads - r0); end
    tests++;
    if (fifo.size() != 1) begin fails++; $display("FAIL bp_fifo_left got %0d required 1", fifo.size()); end
    tests++;
    if ({out_valid, out_data} !== {1'b1, 16'h4321}) begin
      fails++;
      $display("FAIL bp_held valid=%b data=%h required 1 4321", out_valid, out_data);
    end
    out_ready = 1;
    run(12);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL bp_drain pending=%0d required 0", exp_q.size()); end
    tests++;
    if (reads - r0 != 8) begin fails++; $display("FAIL bp_total_reads got %0d required 8", reads - r0); end
  endtask

  task automatic test_empty();
    int v0;
    out_ready = 1;
    v0 = valid_cycles;
    expect_word(16'h4321, 3'd4);
    push(4'h1); push(4'h2);
    run(25);
    tests++;
    if (valid_cycles - v0 != 0) begin fails++; $display("FAIL empty_no_valid got %0d required 0", valid_cycles - v0); end
    tests++;
    if (r_en !== 1'b0) begin fails++; $display("FAIL empty_ren r_en=%b required 0", r_en); end
    push(4'h3); push(4'h4);
    run(10);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL empty_resume pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    int r0, v0;
    out_ready = 1;
    push(4'h1); push(4'h2); push(4'h3);
    run(6);
    flush = 1;
    expect_word(16'h0321, 3'd3);
    r0 = reads; v0 = valid_cycles;
    for (int i = 5; i <= 8; i++) push(DW'(i));
    run(6);
    tests++;
    if (reads - r0 != 0) begin fails++; $display("FAIL flush_blocks_reads got %0d required 0", reads - r0); end
    tests++;
    if (r_en !== 1'b0) begin fails++; $display("FAIL flush_ren r_en=%b required 0", r_en); end
    tests++;
    if (valid_cycles - v0 != 1) begin fails++; $display("FAIL flush_single_emit got %0d required 1", valid_cycles - v0); end
    expect_word(16'h8765, 3'd4);
    flush = 0;
    run(10);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL flush_after pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1;
    push(4'h1); push(4'h2);
    run(4);
    rrst = 1;
    tick();
    rrst = 0;
    tests++;
    if ({out_valid, out_data} !== '0) begin
      fails++;
      $display("FAIL midreset_clear valid=%b data=%h required 0 0000", out_valid, out_data);
    end
    expect_word(16'h8765, 3'd4);
    for (int i = 5; i <= 8; i++) push(DW'(i));
    run(10);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL midreset_word pending=%0d required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int r0;
    logic [OW-1:0] w;
    r0 = reads;
    w = '0;
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom_range(0, 15));
      push(v);
      w[(i % PF)*DW +: DW] = v;
      if (i % PF == PF - 1) expect_word(w, 3'd4);
    end
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1;
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_drain pending=%0d required 0", exp_q.size()); end
    tests++;
    if (reads - r0 != 40) begin fails++; $display("FAIL b2b_reads got %0d required 40", reads - r0); end
    run(3);
  endtask

`ifdef FIFO_RD_PACKER_PARITY_EN
  task automatic test_parity();
    out_ready = 0;
    for (int i = 1; i <= 4; i++) push(DW'(i));
    run(8);
    tests++;
    if (out_parity !== 1'b1) begin fails++; $display("FAIL parity_4321 got %b required 1", out_parity); end
    expect_word(16'h4321, 3'd4);
    out_ready = 1;
    tick();
    out_ready = 0;
    push(4'h0); push(4'h0); push(4'h3); push(4'h3);
    run(8);
    tests++;
    if ({out_parity, out_data} !== {1'b0, 16'h3300}) begin
      fails++;
      $display("FAIL parity_3300 parity=%b data=%h required 0 3300", out_parity, out_data);
    end
    expect_word(16'h3300, 3'd4);
    out_ready = 1;
    run(3);
    tests++;
    if (exp_q.size() != 0) begin fails++; $display("FAIL parity_drain pending=%0d required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty();
    test_flush();
    test_reset_mid();
    test_back_to_back();
`ifdef FIFO_RD_PACKER_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the asynchronous FIFO; lives entirely in the FIFO read clock domain.
- Drains DATA_WIDTH-bit entries through the FIFO's r_en/r_empty/rdata interface.
- Packs PACK_FACTOR consecutive entries into one wide word and presents it downstream on a valid/ready handshake.
- Supports a flush that emits a partially filled word.

Parameters:
DATA_WIDTH, 4, width of FIFO rdata (matches FIFO MEMORY_WIDTH)
PACK_FACTOR, 4, entries per output word; legal values 2 to 16
OUT_WIDTH, DATA_WIDTH*PACK_FACTOR, output word width (derived; do not override)
LANE_W, $clog2(PACK_FACTOR)+1, width of out_lanes (derived)

Ports:
r_clk  in  1  read-domain clock (same clock as FIFO read side)
rrst  in  1  reset, synchronous, active-high
r_empty  in  1  FIFO empty flag
rdata  in  DATA_WIDTH  FIFO read data
r_en  out  1  FIFO read enable
flush  in  1  level; request emission of a partial word
out_data  out  OUT_WIDTH  packed word; entry 0 in bits [DATA_WIDTH-1:0]
out_lanes  out  LANE_W  number of valid entries in out_data (1..PACK_FACTOR)
out_valid  out  1  out_data/out_lanes valid
out_ready  in  1  downstream accepts the word when high with out_valid

Behaviour:
- Reset (rrst high at a r_clk edge) clears these to 0: out_data, out_lanes, out_valid, lane counter cnt, in-flight flag, assembly register.
- r_en is 0 while rrst is high.
- Any FIFO entry whose read was issued on the edge before reset is discarded.
- FIFO read latency:
  - r_en sampled high with r_empty low at edge k advances the FIFO.
  - The entry is valid on rdata after edge k and is captured at edge k+1.
  - inflight register = read accepted at previous edge.
- Capture: at an edge with inflight=1, rdata is written to assembly lane cnt and cnt increments.
- Word completion, when the captured lane is PACK_FACTOR-1:
  - assembly (including the new entry) loads out_data;
  - out_lanes = PACK_FACTOR, out_valid = 1, cnt = 0;
  - assembly is cleared.
- Landing lane of a read issued now = (cnt + inflight) mod PACK_FACTOR.
- r_en = !r_empty && !flush && !stall, where stall = out_valid && !out_ready && landing lane == PACK_FACTOR-1.
- Guarantees: never overflow, never drop an entry. Sustains 1 entry/cycle while out_ready is high.
- Output handshake:
  - A transfer occurs on an edge with out_valid && out_ready.
  - out_valid drops after the transfer unless a new word completes on the same edge (the new word loads directly).
  - out_data and out_lanes are held stable while out_valid && !out_ready.
- Empty: r_en stays low. A partial assembly is held indefinitely; no timeout.
- Flush:
  - While flush is high, no new reads are issued; any in-flight entry still lands.
  - When inflight=0, cnt>0 and (!out_valid || out_ready), the partial word loads the output: upper lanes zero, out_lanes = cnt, out_valid = 1, cnt = 0.
  - flush with cnt=0 produces nothing.
  - Holding flush high after emission has no further effect until more data exists. Since reads are blocked while flush is high, nothing further occurs until flush drops.
- Simultaneous completion and downstream accept on one edge: the new word replaces the old one with no gap.
- cnt wraps PACK_FACTOR-1 → 0 only through completion or flush.

Optional Feature:
FIFO_RD_PACKER_PARITY_EN
- Defined:
  - adds output out_parity (1 bit) = XOR reduction of out_data;
  - registered together with out_data, reset to 0, held under backpressure.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
1. FIFO supplies entries 1,2,3,4 with out_ready=1 → one word: out_data=16'h4321, out_lanes=4, out_valid high for exactly one cycle, 4 r_en pulses.
2. Entries 1..8 with out_ready=0 → out_data=16'h4321 held stable, exactly 7 r_en pulses, FIFO keeps 1 entry. Raise out_ready → 16'h4321 transfers, then 16'h8765 appears after the last read lands.
3. Entries 1,2 then FIFO empty for 20 cycles → no out_valid, r_en low. Then entries 3,4 → 16'h4321.
4. Entries 1,2,3 then flush=1 → r_en stays 0, out_data=16'h0321, out_lanes=3. Drop flush, supply 5..8 → 16'h8765, out_lanes=4.
5. Entries 1,2 captured, rrst high 1 cycle → out_valid=0, cnt=0. Next entries 5,6,7,8 → 16'h8765 (1,2 absent).
6. With FIFO_RD_PACKER_PARITY_EN: word 16'h4321 → out_parity=1. Word 16'h3300 → out_parity=0.
